// File: rtl/riscv_pkg.sv
// Shared RV32I core types: FSM states, opcodes, ALU/extender op codes and
// the datapath mux select encodings used by the main controller.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXCT_R  = 4'd6,
        S_EXCT_I  = 4'd7,
        S_ALU_WB  = 4'd8,
        S_BQ      = 4'd9,
        S_JAL     = 4'd10,
        S_JALR1   = 4'd11,
        S_JALR2   = 4'd12,
        S_LUI     = 4'd13,
        S_AUIPC   = 4'd14
    } state_t;

    typedef enum logic [6:0] {
        OP_L     = 7'b0000011,
        OP_I     = 7'b0010011,
        OP_AUIPC = 7'b0010111,
        OP_S     = 7'b0100011,
        OP_R     = 7'b0110011,
        OP_LUI   = 7'b0110111,
        OP_B     = 7'b1100011,
        OP_JALR  = 7'b1100111,
        OP_JAL   = 7'b1101111
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        EXT_I = 3'd0,
        EXT_S = 3'd1,
        EXT_B = 3'd2,
        EXT_U = 3'd3,
        EXT_J = 3'd4
    } ext_op_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } branch_op_e;

    // Instruction class seen by the ALU decoder
    typedef enum logic [1:0] {
        IR_OP_R = 2'd0,
        IR_OP_I = 2'd1,
        IR_OP_B = 2'd2
    } ir_op_e;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

endpackage

// File: rtl/riscv_alu_dec.sv
// ALU operation decoder: maps funct3/funct7b5 and the instruction class
// (register, immediate or branch compare) onto an alu_op_e.
module riscv_alu_dec
    import riscv_pkg::*;
(
    input  ir_op_e     op_class,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output alu_op_e    alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        if (op_class == IR_OP_B) begin
            // funct3 010/011 are not branches; ADD keeps the compare harmless
            case (funct3)
                BR_EQ, BR_NE:   alu_op = ALU_SUB;
                BR_LT, BR_GE:   alu_op = ALU_SLT;
                BR_LTU, BR_GEU: alu_op = ALU_SLTU;
                default:        alu_op = ALU_ADD;
            endcase
        end else begin
            case (funct3)
                3'b000:  alu_op = (op_class == IR_OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/riscv_main_ctrl.sv
// Multicycle main control FSM for the RV32I core: sequences the shared
// datapath, handshakes with the unified memory port and counts retirements.
module riscv_main_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            alu_zero,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_write,
    output logic            adr_src,
    output logic            ir_write,
    output logic            pc_write,
    output logic            pc_lsb_clr,
    output logic            reg_write,
    output logic [1:0]      result_src,
    output logic [1:0]      alu_src_a,
    output logic [1:0]      alu_src_b,
    output alu_op_e         alu_op,
    output ext_op_e         imm_src,
    output logic            illegal,
    output logic [3:0]      state_o,
    output logic [XLEN-1:0] instret
);

    state_t  state, state_n;
    ir_op_e  op_class;
    alu_op_e dec_op;
    logic    taken;
    logic    retire;
    logic    mem_req_c, mem_write_c, ir_write_c, pc_write_c;
    logic    pc_lsb_clr_c, reg_write_c, illegal_c;

    riscv_alu_dec u_alu_dec (
        .op_class (op_class),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .alu_op   (dec_op)
    );

    always_comb begin
        case (state)
            S_EXCT_R: op_class = IR_OP_R;
            S_BQ:     op_class = IR_OP_B;
            default:  op_class = IR_OP_I;
        endcase
    end

    always_comb begin
        case (funct3)
            BR_EQ:                 taken = alu_zero;
            BR_NE:                 taken = !alu_zero;
            BR_LT, BR_LTU:         taken = !alu_zero;
            BR_GE, BR_GEU:         taken = alu_zero;
            default:               taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= state_n;
            if (retire)
                instret <= instret + XLEN'(1);
        end
    end

    always_comb begin
        state_n      = state;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        pc_lsb_clr_c = 1'b0;
        reg_write_c  = 1'b0;
        illegal_c    = 1'b0;
        adr_src      = 1'b0;
        result_src   = RES_ALUOUT;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RS2;
        alu_op       = ALU_ADD;
        imm_src      = EXT_I;

        case (state)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
                if (mem_ready)
                    state_n = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = (opcode == OP_JAL) ? EXT_J : EXT_B;
                case (opcode)
                    OP_L, OP_S: state_n = S_MEM_ADR;
                    OP_R:       state_n = S_EXCT_R;
                    OP_I:       state_n = S_EXCT_I;
                    OP_B:       state_n = S_BQ;
                    OP_JAL:     state_n = S_JAL;
                    OP_JALR:    state_n = S_JALR1;
                    OP_LUI:     state_n = S_LUI;
                    OP_AUIPC:   state_n = S_AUIPC;
                    default: begin
                        illegal_c = 1'b1;
                        state_n   = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (opcode == OP_S) ? EXT_S : EXT_I;
                state_n   = (opcode == OP_S) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req_c = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready)
                    state_n = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src  = RES_DATA;
                reg_write_c = 1'b1;
                state_n     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src     = 1'b1;
                if (mem_ready)
                    state_n = S_FETCH;
            end
            S_EXCT_R: begin
                alu_src_a = SRCA_RS1;
                alu_op    = dec_op;
                state_n   = S_ALU_WB;
            end
            S_EXCT_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = dec_op;
                state_n   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_c = 1'b1;
                state_n     = S_FETCH;
            end
            S_BQ: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = dec_op;
                pc_write_c = taken;
                state_n    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write_c = 1'b1;
                state_n    = S_ALU_WB;
            end
            S_JALR1: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_n   = S_JALR2;
            end
            S_JALR2: begin
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                pc_write_c   = 1'b1;
                pc_lsb_clr_c = 1'b1;
                state_n      = S_ALU_WB;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
                imm_src   = EXT_U;
                state_n   = S_ALU_WB;
            end
            S_AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = EXT_U;
                state_n   = S_ALU_WB;
            end
            default: state_n = S_FETCH;
        endcase
    end

    // Only completed instructions retire; the illegal path leaves from DECODE
    assign retire = (state_n == S_FETCH) &&
                    (state == S_MEM_WB || state == S_MEM_WR ||
                     state == S_ALU_WB || state == S_BQ);

    // Strobes are qualified by rst_n so a reset mid-access drops them at once
    assign mem_req    = rst_n & mem_req_c;
    assign mem_write  = rst_n & mem_write_c;
    assign ir_write   = rst_n & ir_write_c;
    assign pc_write   = rst_n & pc_write_c;
    assign pc_lsb_clr = rst_n & pc_lsb_clr_c;
    assign reg_write  = rst_n & reg_write_c;
    assign illegal    = rst_n & illegal_c;
    assign state_o    = state;

endmodule

// File: tb/tb_riscv_main_ctrl.sv
// Directed bench for riscv_main_ctrl: a vector table of single instructions
// plus hand-written wait-state, illegal-opcode and reset sequences.
module tb_riscv_main_ctrl;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        alu_zero;
    logic        mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, pc_lsb_clr, reg_write;
    logic [1:0]  result_src, alu_src_a, alu_src_b;
    logic [3:0]  alu_op;
    logic [2:0]  imm_src;
    logic        illegal;
    logic [3:0]  state_o;
    logic [31:0] instret;
    logic [20:0] act_o;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_instret;

    riscv_main_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .pc_lsb_clr(pc_lsb_clr),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
        .illegal(illegal), .state_o(state_o), .instret(instret)
    );

    always #5 clk = ~clk;

    assign act_o = {mem_req, mem_write, adr_src, ir_write, pc_write, pc_lsb_clr,
                    reg_write, result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal};

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [3:0]  st;
        logic [20:0] exp;
        int unsigned len;
        int unsigned ret;
    } vec_t;

    vec_t vecs[28];

    function automatic logic [20:0] mk(input logic mr, mw, ad, irw, pcw, lsb, rw,
                                       input logic [1:0] res, a, b,
                                       input logic [3:0] op, input logic [2:0] imm,
                                       input logic ill);
        return {mr, mw, ad, irw, pcw, lsb, rw, res, a, b, op, imm, ill};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input int unsigned i);
        int unsigned cyc;
        logic seen;
        opcode = vecs[i].opc; funct3 = vecs[i].f3; funct7b5 = vecs[i].f7;
        alu_zero = vecs[i].z; mem_ready = 1'b1;
        #1;
        cyc = 0; seen = 1'b0;
        do begin
            if (!seen && state_o == vecs[i].st) begin
                seen = 1'b1;
                chk($sformatf("vec%0d_out", i), {11'd0, act_o}, {11'd0, vecs[i].exp});
            end
            step();
            cyc++;
        end while (state_o != S_FETCH && cyc < 12);
        chk($sformatf("vec%0d_seen", i), {31'd0, seen}, 32'd1);
        chk($sformatf("vec%0d_len", i), cyc, vecs[i].len);
        exp_instret += vecs[i].ret;
        chk($sformatf("vec%0d_instret", i), instret, exp_instret);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int unsigned n, wcnt, rwcnt;

        vecs[0]  = '{OP_R, 3'd0, 1'b0, 1'b0, S_EXCT_R, mk(0,0,0,0,0,0,0,0,2,0,0,0,0), 4, 1};
        vecs[1]  = '{OP_R, 3'd0, 1'b1, 1'b0, S_EXCT_R, mk(0,0,0,0,0,0,0,0,2,0,1,0,0), 4, 1};
        vecs[2]  = '{OP_R, 3'd5, 1'b1, 1'b0, S_EXCT_R, mk(0,0,0,0,0,0,0,0,2,0,7,0,0), 4, 1};
        vecs[3]  = '{OP_R, 3'd3, 1'b0, 1'b0, S_EXCT_R, mk(0,0,0,0,0,0,0,0,2,0,4,0,0), 4, 1};
        vecs[4]  = '{OP_I, 3'd0, 1'b1, 1'b0, S_EXCT_I, mk(0,0,0,0,0,0,0,0,2,1,0,0,0), 4, 1};
        vecs[5]  = '{OP_I, 3'd5, 1'b1, 1'b0, S_EXCT_I, mk(0,0,0,0,0,0,0,0,2,1,7,0,0), 4, 1};
        vecs[6]  = '{OP_I, 3'd7, 1'b0, 1'b0, S_EXCT_I, mk(0,0,0,0,0,0,0,0,2,1,9,0,0), 4, 1};
        vecs[7]  = '{OP_B, 3'd1, 1'b0, 1'b0, S_BQ,     mk(0,0,0,0,1,0,0,0,2,0,1,0,0), 3, 1};
        vecs[8]  = '{OP_B, 3'd1, 1'b0, 1'b1, S_BQ,     mk(0,0,0,0,0,0,0,0,2,0,1,0,0), 3, 1};
        vecs[9]  = '{OP_B, 3'd0, 1'b0, 1'b1, S_BQ,     mk(0,0,0,0,1,0,0,0,2,0,1,0,0), 3, 1};
        vecs[10] = '{OP_B, 3'd7, 1'b0, 1'b1, S_BQ,     mk(0,0,0,0,1,0,0,0,2,0,4,0,0), 3, 1};
        vecs[11] = '{OP_B, 3'd4, 1'b0, 1'b0, S_BQ,     mk(0,0,0,0,1,0,0,0,2,0,3,0,0), 3, 1};
        vecs[12] = '{OP_B, 3'd2, 1'b0, 1'b1, S_BQ,     mk(0,0,0,0,0,0,0,0,2,0,0,0,0), 3, 1};
        vecs[13] = '{OP_JAL, 3'd0, 1'b0, 1'b0, S_DECODE, mk(0,0,0,0,0,0,0,0,1,1,0,4,0), 4, 1};
        vecs[14] = '{OP_JAL, 3'd0, 1'b0, 1'b0, S_JAL,    mk(0,0,0,0,1,0,0,0,1,2,0,0,0), 4, 1};
        vecs[15] = '{OP_JALR, 3'd0, 1'b0, 1'b0, S_JALR2, mk(0,0,0,0,1,1,0,0,1,2,0,0,0), 5, 1};
        vecs[16] = '{OP_JALR, 3'd0, 1'b0, 1'b0, S_JALR1, mk(0,0,0,0,0,0,0,0,2,1,0,0,0), 5, 1};
        vecs[17] = '{OP_LUI, 3'd0, 1'b0, 1'b0, S_LUI,     mk(0,0,0,0,0,0,0,0,3,1,0,3,0), 4, 1};
        vecs[18] = '{OP_AUIPC, 3'd0, 1'b0, 1'b0, S_AUIPC, mk(0,0,0,0,0,0,0,0,1,1,0,3,0), 4, 1};
        vecs[19] = '{OP_L, 3'd2, 1'b0, 1'b0, S_MEM_ADR, mk(0,0,0,0,0,0,0,0,2,1,0,0,0), 5, 1};
        vecs[20] = '{OP_L, 3'd2, 1'b0, 1'b0, S_MEM_WB,  mk(0,0,0,0,0,0,1,1,0,0,0,0,0), 5, 1};
        vecs[21] = '{OP_S, 3'd2, 1'b0, 1'b0, S_MEM_ADR, mk(0,0,0,0,0,0,0,0,2,1,0,1,0), 4, 1};
        vecs[22] = '{OP_S, 3'd2, 1'b0, 1'b0, S_MEM_WR,  mk(1,1,1,0,0,0,0,0,0,0,0,0,0), 4, 1};
        vecs[23] = '{OP_L, 3'd2, 1'b0, 1'b0, S_MEM_RD,  mk(1,0,1,0,0,0,0,0,0,0,0,0,0), 5, 1};
        vecs[24] = '{7'd0, 3'd0, 1'b0, 1'b0, S_DECODE,  mk(0,0,0,0,0,0,0,0,1,1,0,2,1), 2, 0};
        vecs[25] = '{OP_R, 3'd0, 1'b0, 1'b0, S_ALU_WB,  mk(0,0,0,0,0,0,1,0,0,0,0,0,0), 4, 1};
        vecs[26] = '{OP_R, 3'd0, 1'b0, 1'b0, S_FETCH,   mk(1,0,0,1,1,0,0,2,0,2,0,0,0), 4, 1};
        vecs[27] = '{OP_B, 3'd1, 1'b0, 1'b0, S_DECODE,  mk(0,0,0,0,0,0,0,0,1,1,0,2,0), 3, 1};

        // Reset with mem_ready high: strobes must stay low
        rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_R; funct3 = 3'd0;
        funct7b5 = 1'b0; alu_zero = 1'b0; exp_instret = 32'd0;
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_ir_write", {31'd0, ir_write}, 32'd0);
        chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
        chk("rst_state", {28'd0, state_o}, {28'd0, S_FETCH});
        chk("rst_instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("fetch_mem_req", {31'd0, mem_req}, 32'd1);
        chk("fetch_ir_pc_write", {30'd0, ir_write, pc_write}, 32'd3);
        step();
        chk("first_edge_state", {28'd0, state_o}, {28'd0, S_DECODE});
        step(); step(); step();
        exp_instret = 32'd1;
        chk("first_add_state", {28'd0, state_o}, {28'd0, S_FETCH});
        chk("first_add_instret", instret, exp_instret);

        for (int unsigned i = 0; i < 28; i++)
            run_vec(i);

        // Fetch with mem_ready low for two cycles
        opcode = OP_R; funct3 = 3'd0; funct7b5 = 1'b0;
        n = 0;
        while (state_o == S_FETCH && n < 10) begin
            mem_ready = (n == 2);
            #1;
            if (n == 0) chk("fetchwait_ir_write", {31'd0, ir_write}, 32'd0);
            if (n == 0) chk("fetchwait_mem_req", {31'd0, mem_req}, 32'd1);
            step();
            n++;
        end
        chk("fetchwait_cycles", n, 32'd3);
        mem_ready = 1'b1;
        chk("fetchwait_decode", {28'd0, state_o}, {28'd0, S_DECODE});
        step();
        chk("fetchwait_exct", {28'd0, state_o, alu_op}, {24'd0, S_EXCT_R, 4'd0});
        step();
        chk("fetchwait_wb", {27'd0, state_o, reg_write}, {27'd0, S_ALU_WB, 1'b1});
        step();
        exp_instret += 1;
        chk("fetchwait_instret", instret, exp_instret);

        // Load with three wait cycles in MEM_RD
        opcode = OP_L; funct3 = 3'd2; mem_ready = 1'b1;
        #1;
        step(); step();
        chk("lw_memadr", {25'd0, state_o, imm_src}, {25'd0, S_MEM_ADR, 3'd0});
        step();
        n = 0;
        while (state_o == S_MEM_RD && n < 10) begin
            mem_ready = (n == 3);
            #1;
            step();
            n++;
        end
        chk("lw_rd_cycles", n, 32'd4);
        mem_ready = 1'b1;
        #1;
        chk("lw_wb", {27'd0, state_o, reg_write}, {27'd0, S_MEM_WB, 1'b1});
        step();
        exp_instret += 1;
        chk("lw_instret", instret, exp_instret);

        // Store with two wait cycles in MEM_WR
        opcode = OP_S; mem_ready = 1'b1;
        #1;
        step(); step(); step();
        n = 0; wcnt = 0; rwcnt = 0;
        while (state_o == S_MEM_WR && n < 10) begin
            mem_ready = (n == 2);
            #1;
            if (mem_write) wcnt++;
            if (reg_write) rwcnt++;
            step();
            n++;
        end
        mem_ready = 1'b1;
        chk("sw_write_cycles", wcnt, 32'd3);
        chk("sw_reg_write", rwcnt, 32'd0);
        chk("sw_back_fetch", {28'd0, state_o}, {28'd0, S_FETCH});
        exp_instret += 1;
        chk("sw_instret", instret, exp_instret);

        // Illegal opcode: single-cycle pulse, no retire
        opcode = 7'd0;
        #1;
        step();
        chk("ill_pulse", {31'd0, illegal}, 32'd1);
        step();
        chk("ill_drop", {27'd0, state_o, illegal}, {27'd0, S_FETCH, 1'b0});
        chk("ill_instret", instret, exp_instret);

        // Reset asserted while waiting in MEM_RD
        opcode = OP_L;
        #1;
        step(); step(); step();
        mem_ready = 1'b0;
        #1;
        chk("midrst_pre", {27'd0, state_o, mem_req}, {27'd0, S_MEM_RD, 1'b1});
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_state", {28'd0, state_o}, {28'd0, S_FETCH});
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1;
        #1;
        chk("midrst_release", {27'd0, state_o, mem_req}, {27'd0, S_FETCH, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
